sbox_share_sched: RTL



---
 rtl/sbox_share_sched_if.sv | 40 ++++
 rtl/sbox_share_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sbox_share_sched_if.sv
// Request/result handshakes and S-box lane bus for sbox_share_sched.
// slave = scheduler side, master = requesters plus external S-box lanes.
interface sbox_share_sched_if #(
    parameter int SBOX_LANES = 4
);
    logic                      dp_req;
    logic                      dp_mode;
    logic [127:0]              dp_data;
    logic                      dp_ack;
    logic                      dp_done;
    logic [127:0]              dp_result;

    logic                      ks_req;
    logic [31:0]               ks_data;
    logic                      ks_ack;
    logic                      ks_done;
    logic [31:0]               ks_result;

    logic [8*SBOX_LANES-1:0]   sbox_in;
    logic                      sbox_mode;
    logic [8*SBOX_LANES-1:0]   sbox_out;

    modport master (
        output dp_req, dp_mode, dp_data,
        input  dp_ack, dp_done, dp_result,
        output ks_req, ks_data,
        input  ks_ack, ks_done, ks_result,
        input  sbox_in, sbox_mode,
        output sbox_out
    );

    modport slave (
        input  dp_req, dp_mode, dp_data,
        output dp_ack, dp_done, dp_result,
        input  ks_req, ks_data,
        output ks_ack, ks_done, ks_result,
        output sbox_in, sbox_mode,
        input  sbox_out
    );
endinterface

// File: rtl/sbox_share_sched.sv
// Shares SBOX_LANES external AES S-box lanes between the round datapath (16 B) and
// key expansion (4 B SubWord). Define SBOX_SCHED_PERF_EN for perf_dp_ops/perf_ks_wait.
module sbox_share_sched #(
    parameter int SBOX_LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    sbox_share_sched_if.slave  bus,
`ifdef SBOX_SCHED_PERF_EN
    output logic [15:0]        perf_dp_ops,
    output logic [15:0]        perf_ks_wait,
`endif
    output logic               busy
);
    localparam int LW   = 8 * SBOX_LANES;
    localparam int N_DP = 16 / SBOX_LANES;
    localparam int N_KS = 4 / SBOX_LANES;

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
        $error("sbox_share_sched: SBOX_LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, DP_RUN, KS_RUN} state_t;
    typedef enum logic {OWNER_DP, OWNER_KS} owner_t;

    state_t         state;
    owner_t         last_grant;
    logic [3:0]     beat;
    logic [127:0]   work;
    logic           work_mode;
    logic [127:0]   acc;
    logic [127:0]   acc_next;
    logic [127:0]   dp_result_q;
    logic [31:0]    ks_result_q;
    logic           dp_done_q;
    logic           ks_done_q;
    logic           grant_dp;
    logic           grant_ks;
    logic           last_beat;
    logic [6:0]     base;
    logic [LW-1:0]  lane_in;
    logic           lane_mode;

    // Grant is decided combinationally in IDLE so ack coincides with data capture.
    always_comb begin
        grant_dp = 1'b0;
        grant_ks = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.dp_req && bus.ks_req) begin
                grant_ks = (last_grant == OWNER_DP);
                grant_dp = (last_grant == OWNER_KS);
            end else begin
                grant_dp = bus.dp_req;
                grant_ks = bus.ks_req;
            end
        end
    end

    always_comb begin
        base      = 7'(beat * LW);
        lane_in   = '0;
        lane_mode = 1'b0;
        acc_next  = acc;
        last_beat = 1'b0;
        if (state != IDLE) begin
            lane_in              = work[base +: LW];
            acc_next[base +: LW] = bus.sbox_out;
            lane_mode            = (state == DP_RUN) ? work_mode : 1'b0;
            last_beat            = (state == DP_RUN) ? (beat == 4'(N_DP - 1))
                                                     : (beat == 4'(N_KS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= OWNER_DP;
            beat        <= '0;
            work        <= '0;
            work_mode   <= 1'b0;
            acc         <= '0;
            dp_result_q <= '0;
            ks_result_q <= '0;
            dp_done_q   <= 1'b0;
            ks_done_q   <= 1'b0;
        end else begin
            dp_done_q <= 1'b0;
            ks_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (grant_dp) begin
                        work       <= bus.dp_data;
                        work_mode  <= bus.dp_mode;
                        last_grant <= OWNER_DP;
                        state      <= DP_RUN;
                    end else if (grant_ks) begin
                        work       <= {96'b0, bus.ks_data};
                        work_mode  <= 1'b0;
                        last_grant <= OWNER_KS;
                        state      <= KS_RUN;
                    end
                end
                DP_RUN, KS_RUN: begin
                    acc  <= acc_next;
                    beat <= beat + 4'd1;
                    if (last_beat) begin
                        state <= IDLE;
                        beat  <= '0;
                        if (state == DP_RUN) begin
                            dp_result_q <= acc_next;
                            dp_done_q   <= 1'b1;
                        end else begin
                            ks_result_q <= acc_next[31:0];
                            ks_done_q   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dp_ack    = grant_dp;
    assign bus.ks_ack    = grant_ks;
    assign bus.dp_done   = dp_done_q;
    assign bus.ks_done   = ks_done_q;
    assign bus.dp_result = dp_result_q;
    assign bus.ks_result = ks_result_q;
    assign bus.sbox_in   = lane_in;
    assign bus.sbox_mode = lane_mode;
    assign busy          = (state != IDLE);

`ifdef SBOX_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dp_ops  <= '0;
            perf_ks_wait <= '0;
        end else begin
            if (grant_dp && perf_dp_ops != '1)
                perf_dp_ops <= perf_dp_ops + 16'd1;
            if (bus.ks_req && !grant_ks && perf_ks_wait != '1)
                perf_ks_wait <= perf_ks_wait + 16'd1;
        end
    end
`endif
endmodule
